id_ex_operand_stage: RTL and testbench

- Decode/operand stage directly downstream of the 8x16 register file.
- Drives the register file read addresses and resolves RAW hazards by forwarding from EX, MEM and WB.
- Inserts a one-cycle bubble on load-use and registers the resolved operands into the ID/EX pipeline register consumed by the ALU.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/operand_forward_mux.sv | 45 ++++
 rtl/id_ex_operand_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths, forward-select encoding and the ID/EX register layout.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int CTRL_W = 8;
    localparam int BCNT_W = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_EX  = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] a_dat;
        logic [DATA_W-1:0] b_dat;
        logic [ADDR_W-1:0] rd;
        logic              is_load;
        logic              reg_write;
        logic [CTRL_W-1:0] ctrl;
    } idex_t;

endpackage

// File: rtl/operand_forward_mux.sv
// Priority forward select for one source operand (EX > MEM > WB > register file).
// Latency: combinational.
// Backpressure: none; pure datapath.
module operand_forward_mux
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] src_i,
    input  logic              used_i,
    input  logic              ex_vld_i,
    input  logic [ADDR_W-1:0] ex_rd_i,
    input  logic [DATA_W-1:0] ex_dat_i,
    input  logic              mem_vld_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_dat_i,
    input  logic              wb_vld_i,
    input  logic [ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0] wb_dat_i,
    input  logic [DATA_W-1:0] rf_dat_i,
    output logic [DATA_W-1:0] dat_o
);

    fwd_sel_e sel;

    always_comb begin
        sel = FWD_RF;
        if (used_i) begin
            if (ex_vld_i && (ex_rd_i == src_i))
                sel = FWD_EX;
            else if (mem_vld_i && (mem_rd_i == src_i))
                sel = FWD_MEM;
            else if (wb_vld_i && (wb_rd_i == src_i))
                sel = FWD_WB;
        end
    end

    always_comb begin
        case (sel)
            FWD_EX:  dat_o = ex_dat_i;
            FWD_MEM: dat_o = mem_dat_i;
            FWD_WB:  dat_o = wb_dat_i;
            default: dat_o = rf_dat_i;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// Decode/operand stage: RAW forwarding from EX/MEM/WB, load-use bubble, ID/EX register.
// Latency: 1 cycle from acceptance to out_valid; a load-use dependency adds one bubble.
// Backpressure: in_ready drops on ex_hold or load-use; ex_hold freezes the ID/EX register.
module id_ex_operand_stage
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs,
    input  logic [ADDR_W-1:0] in_rt,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_reads_rs,
    input  logic              in_reads_rt,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_is_load,
    input  logic              in_reg_write,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [ADDR_W-1:0] rf_rreg1,
    output logic [ADDR_W-1:0] rf_rreg2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_wr,
    input  logic [DATA_W-1:0] wb_wd,
    input  logic              ex_hold,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_is_load,
    output logic              out_reg_write,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [BCNT_W-1:0] bubble_count
);

    idex_t             idex_q, idex_d;
    logic [BCNT_W-1:0] bubble_q, bubble_d;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic              ex_fwd_vld, mem_fwd_vld, load_use;

    assign rf_rreg1 = in_rs;
    assign rf_rreg2 = in_rt;

    // A load in EX has no data yet, so it must never be an EX forward source.
    assign ex_fwd_vld  = idex_q.vld && idex_q.reg_write && !idex_q.is_load;
    assign mem_fwd_vld = mem_valid && mem_reg_write;

    operand_forward_mux u_fwd_rs (
        .src_i     (in_rs),
        .used_i    (in_reads_rs),
        .ex_vld_i  (ex_fwd_vld),
        .ex_rd_i   (idex_q.rd),
        .ex_dat_i  (ex_result),
        .mem_vld_i (mem_fwd_vld),
        .mem_rd_i  (mem_rd),
        .mem_dat_i (mem_result),
        .wb_vld_i  (wb_we),
        .wb_rd_i   (wb_wr),
        .wb_dat_i  (wb_wd),
        .rf_dat_i  (rf_rdata1),
        .dat_o     (fwd_a)
    );

    operand_forward_mux u_fwd_rt (
        .src_i     (in_rt),
        .used_i    (in_reads_rt),
        .ex_vld_i  (ex_fwd_vld),
        .ex_rd_i   (idex_q.rd),
        .ex_dat_i  (ex_result),
        .mem_vld_i (mem_fwd_vld),
        .mem_rd_i  (mem_rd),
        .mem_dat_i (mem_result),
        .wb_vld_i  (wb_we),
        .wb_rd_i   (wb_wr),
        .wb_dat_i  (wb_wd),
        .rf_dat_i  (rf_rdata2),
        .dat_o     (fwd_b)
    );

    assign load_use = in_valid && idex_q.vld && idex_q.is_load && idex_q.reg_write &&
                      ((in_reads_rs && (idex_q.rd == in_rs)) ||
                       (in_reads_rt && !in_use_imm && (idex_q.rd == in_rt)));

    assign in_ready = !ex_hold && !load_use;

    always_comb begin
        idex_d   = idex_q;
        bubble_d = bubble_q;
        if (flush) begin
            idex_d.vld = 1'b0;
        end else if (!ex_hold) begin
            if (load_use) begin
                idex_d.vld = 1'b0;
                if (bubble_q != {BCNT_W{1'b1}})
                    bubble_d = bubble_q + 1'b1;
            end else begin
                idex_d.vld       = in_valid;
                idex_d.a_dat     = fwd_a;
                idex_d.b_dat     = in_use_imm ? in_imm : fwd_b;
                idex_d.rd        = in_rd;
                idex_d.is_load   = in_is_load;
                idex_d.reg_write = in_reg_write;
                idex_d.ctrl      = in_ctrl;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q   <= '0;
            bubble_q <= '0;
        end else begin
            idex_q   <= idex_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_valid     = idex_q.vld;
    assign out_a         = idex_q.a_dat;
    assign out_b         = idex_q.b_dat;
    assign out_rd        = idex_q.rd;
    assign out_is_load   = idex_q.is_load;
    assign out_reg_write = idex_q.reg_write;
    assign out_ctrl      = idex_q.ctrl;
    assign bubble_count  = bubble_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table, hold/flush/saturation/reset
// sequences, then randomized traffic against a youngest-producer reference model.
module tb_id_ex_operand_stage;

    logic        clock, reset;
    logic        in_valid, in_ready;
    logic [2:0]  in_rs, in_rt, in_rd;
    logic        in_reads_rs, in_reads_rt, in_use_imm;
    logic [15:0] in_imm;
    logic        in_is_load, in_reg_write;
    logic [7:0]  in_ctrl;
    logic [2:0]  rf_rreg1, rf_rreg2;
    logic [15:0] rf_rdata1, rf_rdata2, ex_result;
    logic        mem_valid, mem_reg_write;
    logic [2:0]  mem_rd;
    logic [15:0] mem_result;
    logic        wb_we;
    logic [2:0]  wb_wr;
    logic [15:0] wb_wd;
    logic        ex_hold, flush;
    logic        out_valid;
    logic [15:0] out_a, out_b;
    logic [2:0]  out_rd;
    logic        out_is_load, out_reg_write;
    logic [7:0]  out_ctrl;
    logic [15:0] bubble_count;

    int total = 0;
    int bad   = 0;

    id_ex_operand_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_reads_rs(in_reads_rs), .in_reads_rt(in_reads_rt),
        .in_use_imm(in_use_imm), .in_imm(in_imm),
        .in_is_load(in_is_load), .in_reg_write(in_reg_write), .in_ctrl(in_ctrl),
        .rf_rreg1(rf_rreg1), .rf_rreg2(rf_rreg2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_result(ex_result),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_we(wb_we), .wb_wr(wb_wr), .wb_wd(wb_wd),
        .ex_hold(ex_hold), .flush(flush),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_rd(out_rd),
        .out_is_load(out_is_load), .out_reg_write(out_reg_write),
        .out_ctrl(out_ctrl), .bubble_count(bubble_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [2:0]  rs, rt, rd;
        logic        rrs, rrt, ui;
        logic [15:0] imm, rf1, rf2, exr;
        logic        mv;
        logic [2:0]  mrd;
        logic [15:0] mres;
        logic        wwe;
        logic [2:0]  wwr;
        logic [15:0] wwd;
        logic        ld, rw;
        logic        e_rdy, e_vld;
        logic [15:0] e_a, e_b, e_bub;
    } vec_t;

    vec_t vt[11];

    // Reference model of the ID/EX register contents.
    logic        m_vld, m_ld, m_rw;
    logic [15:0] m_a, m_b, m_bub;
    logic [2:0]  m_rd;
    logic [7:0]  m_ctrl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_reads_rs = 0; in_reads_rt = 0; in_use_imm = 0; in_imm = 0;
        in_is_load = 0; in_reg_write = 0; in_ctrl = 0;
        rf_rdata1 = 0; rf_rdata2 = 0; ex_result = 0;
        mem_valid = 0; mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_we = 0; wb_wr = 0; wb_wd = 0; ex_hold = 0; flush = 0;
    endtask

    task automatic apply(input vec_t t, input logic [7:0] ctl);
        in_valid = t.v; in_rs = t.rs; in_rt = t.rt; in_rd = t.rd;
        in_reads_rs = t.rrs; in_reads_rt = t.rrt; in_use_imm = t.ui; in_imm = t.imm;
        rf_rdata1 = t.rf1; rf_rdata2 = t.rf2; ex_result = t.exr;
        mem_valid = t.mv; mem_reg_write = t.mv; mem_rd = t.mrd; mem_result = t.mres;
        wb_we = t.wwe; wb_wr = t.wwr; wb_wd = t.wwd;
        in_is_load = t.ld; in_reg_write = t.rw; in_ctrl = ctl;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_a"}, out_a, 0);
        chk({tag, "_b"}, out_b, 0);
        chk({tag, "_rd"}, out_rd, 0);
        chk({tag, "_is_load"}, out_is_load, 0);
        chk({tag, "_reg_write"}, out_reg_write, 0);
        chk({tag, "_ctrl"}, out_ctrl, 0);
        chk({tag, "_bubbles"}, bubble_count, 0);
    endtask

    // Value the instruction should see for src: youngest in-flight producer, else the RF read.
    function automatic logic [15:0] resolve(input logic [2:0] src, input logic used,
                                            input logic [15:0] rf);
        logic [2:0]  prod_rd[$];
        logic [15:0] prod_val[$];
        if (!used) return rf;
        if (m_vld && m_rw && !m_ld) begin prod_rd.push_back(m_rd); prod_val.push_back(ex_result); end
        if (mem_valid && mem_reg_write) begin prod_rd.push_back(mem_rd); prod_val.push_back(mem_result); end
        if (wb_we) begin prod_rd.push_back(wb_wr); prod_val.push_back(wb_wd); end
        foreach (prod_rd[k]) if (prod_rd[k] == src) return prod_val[k];
        return rf;
    endfunction

    function automatic logic model_stall();
        logic need_rs, need_rt;
        need_rs = in_reads_rs && (in_rs == m_rd);
        need_rt = in_reads_rt && !in_use_imm && (in_rt == m_rd);
        return in_valid && m_vld && m_ld && m_rw && (need_rs || need_rt);
    endfunction

    initial begin
        //            v  rs rt rd rrs rrt ui imm      rf1      rf2      exr      mv mrd mres     wwe wwr wwd      ld rw  rdy vld a        b        bub
        vt[0]  = '{1, 1, 2, 3, 1, 1, 0, 16'h0000, 16'h0011, 16'h0022, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,  1, 1, 16'h0011, 16'h0022, 16'd0};
        vt[1]  = '{1, 3, 2, 3, 1, 1, 0, 16'h0000, 16'h0AAA, 16'h0BBB, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,  1, 1, 16'h1234, 16'h0BBB, 16'd0};
        vt[2]  = '{1, 3, 7, 5, 1, 1, 0, 16'h0000, 16'h0AAA, 16'h0777, 16'h1234, 1, 3, 16'h5555, 0, 0, 16'h0000, 0, 0,  1, 1, 16'h1234, 16'h0777, 16'd0};
        vt[3]  = '{1, 5, 1, 2, 1, 1, 1, 16'hFFF0, 16'h0000, 16'h9999, 16'h0000, 0, 0, 16'h0000, 1, 5, 16'hBEEF, 0, 1,  1, 1, 16'hBEEF, 16'hFFF0, 16'd0};
        vt[4]  = '{1, 4, 4, 4, 1, 1, 0, 16'h0000, 16'h0001, 16'h0002, 16'h2222, 1, 4, 16'h4444, 1, 4, 16'h8888, 1, 1,  1, 1, 16'h4444, 16'h4444, 16'd0};
        vt[5]  = '{1, 1, 4, 1, 1, 1, 0, 16'h0000, 16'h0101, 16'h0000, 16'hDEAD, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1,  0, 0, 16'h0000, 16'h0000, 16'd1};
        vt[6]  = '{1, 1, 4, 1, 1, 1, 0, 16'h0000, 16'h0101, 16'h0000, 16'hDEAD, 1, 4, 16'hCAFE, 0, 0, 16'h0000, 0, 1,  1, 1, 16'h0101, 16'hCAFE, 16'd1};
        vt[7]  = '{1, 1, 1, 0, 0, 1, 1, 16'h0042, 16'h1111, 16'h2222, 16'h7777, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 1, 16'h1111, 16'h0042, 16'd1};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h3333, 16'h4444, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 0, 16'h0000, 16'h0000, 16'd1};
        vt[9]  = '{1, 2, 6, 6, 1, 1, 0, 16'h0000, 16'h0202, 16'h0606, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 1,  1, 1, 16'h0202, 16'h0606, 16'd1};
        vt[10] = '{1, 0, 6, 0, 1, 1, 1, 16'h1357, 16'h0000, 16'h0606, 16'hDEAD, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0,  1, 1, 16'h0000, 16'h1357, 16'd1};

        clear_inputs();
        reset = 1;
        step();
        step();
        chk_all_zero("reset");
        reset = 0;

        for (int i = 0; i < 11; i++) begin
            apply(vt[i], 8'(8'h10 + i));
            #1;
            chk($sformatf("vec%0d_ready", i), in_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d_rreg1", i), rf_rreg1, vt[i].rs);
            step();
            chk($sformatf("vec%0d_valid", i), out_valid, vt[i].e_vld);
            chk($sformatf("vec%0d_bubbles", i), bubble_count, vt[i].e_bub);
            if (vt[i].e_vld) begin
                chk($sformatf("vec%0d_a", i), out_a, vt[i].e_a);
                chk($sformatf("vec%0d_b", i), out_b, vt[i].e_b);
                chk($sformatf("vec%0d_rd", i), out_rd, vt[i].rd);
                chk($sformatf("vec%0d_ctrl", i), out_ctrl, 8'(8'h10 + i));
            end
        end

        // EX hold freezes a valid instruction; flush overrides the hold.
        clear_inputs();
        in_valid = 1; in_rs = 2; in_rt = 3; in_rd = 7; in_reads_rs = 1; in_reads_rt = 1;
        in_reg_write = 1; in_ctrl = 8'h5A; rf_rdata1 = 16'h00A1; rf_rdata2 = 16'h00B2;
        step();
        chk("hold_setup_a", out_a, 16'h00A1);
        for (int c = 0; c < 3; c++) begin
            ex_hold = 1; in_rs = 3'(c); in_rd = 3'(c); rf_rdata1 = 16'hFFFF;
            ex_result = 16'h9000 + 16'(c); in_ctrl = 8'hC0;
            #1;
            chk($sformatf("hold%0d_ready", c), in_ready, 0);
            step();
            chk($sformatf("hold%0d_valid", c), out_valid, 1);
            chk($sformatf("hold%0d_a", c), out_a, 16'h00A1);
            chk($sformatf("hold%0d_b", c), out_b, 16'h00B2);
            chk($sformatf("hold%0d_rd", c), out_rd, 7);
            chk($sformatf("hold%0d_ctrl", c), out_ctrl, 8'h5A);
        end
        flush = 1;
        step();
        chk("flush_over_hold_valid", out_valid, 0);

        // Saturating bubble counter: each bubble takes a capture plus a stall cycle.
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        in_valid = 1; in_rs = 4; in_reads_rs = 1; in_rd = 4; in_is_load = 1; in_reg_write = 1;
        step();
        for (int k = 0; k < 65539; k++) begin
            step();
            step();
            if (k == 999) chk("sat_midway", bubble_count, 16'd1000);
        end
        chk("sat_count", bubble_count, 16'hFFFF);
        chk("sat_stall_ready", in_ready, 0);
        reset = 1;
        step();
        chk_all_zero("reset_in_stall");
        reset = 0;
        #1;
        chk("post_reset_ready", in_ready, 1);

        // Randomized traffic against the reference model.
        clear_inputs();
        reset = 1;
        step();
        reset = 0;
        m_vld = 0; m_ld = 0; m_rw = 0; m_a = 0; m_b = 0; m_bub = 0; m_rd = 0; m_ctrl = 0;
        for (int c = 0; c < 400; c++) begin
            logic        stall, exp_rdy;
            logic [15:0] na, nb;
            in_valid = ($urandom_range(0, 3) != 0);
            in_rs = 3'($urandom_range(0, 3)); in_rt = 3'($urandom_range(0, 3));
            in_rd = 3'($urandom_range(0, 3));
            in_reads_rs = 1'($urandom); in_reads_rt = 1'($urandom); in_use_imm = 1'($urandom);
            in_imm = 16'($urandom); in_ctrl = 8'($urandom);
            in_is_load = ($urandom_range(0, 2) == 0); in_reg_write = ($urandom_range(0, 3) != 0);
            rf_rdata1 = 16'($urandom); rf_rdata2 = 16'($urandom); ex_result = 16'($urandom);
            mem_valid = 1'($urandom); mem_reg_write = 1'($urandom);
            mem_rd = 3'($urandom_range(0, 3)); mem_result = 16'($urandom);
            wb_we = 1'($urandom); wb_wr = 3'($urandom_range(0, 3)); wb_wd = 16'($urandom);
            ex_hold = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 49) == 0);
            #1;
            stall = model_stall();
            exp_rdy = !ex_hold && !stall;
            chk("rnd_ready", in_ready, exp_rdy);
            na = resolve(in_rs, in_reads_rs, rf_rdata1);
            nb = in_use_imm ? in_imm : resolve(in_rt, in_reads_rt, rf_rdata2);
            if (reset) begin
                m_vld = 0; m_ld = 0; m_rw = 0; m_a = 0; m_b = 0; m_bub = 0; m_rd = 0; m_ctrl = 0;
            end else if (flush) begin
                m_vld = 0;
            end else if (!ex_hold) begin
                if (stall) begin
                    m_vld = 0;
                    if (m_bub != 16'hFFFF) m_bub = m_bub + 1;
                end else begin
                    m_vld = in_valid; m_a = na; m_b = nb; m_rd = in_rd;
                    m_ld = in_is_load; m_rw = in_reg_write; m_ctrl = in_ctrl;
                end
            end
            step();
            chk("rnd_valid", out_valid, m_vld);
            chk("rnd_a", out_a, m_a);
            chk("rnd_b", out_b, m_b);
            chk("rnd_rd", out_rd, m_rd);
            chk("rnd_is_load", out_is_load, m_ld);
            chk("rnd_reg_write", out_reg_write, m_rw);
            chk("rnd_ctrl", out_ctrl, m_ctrl);
            chk("rnd_bubbles", bubble_count, m_bub);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
